// File: rtl/result_tx_seq_pkg.sv
// Shared state encodings and UART framing constants for the result
// transmitter. Build option: RESULT_TX_CHECKSUM_EN.
package result_tx_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_FRAME_BITS = UART_DATA_BITS + 2;

endpackage

// File: rtl/result_tx_seq_uart_tx_byte.sv
// 8N1 byte serializer with bit timer; accepts a new byte on the
// cycle its previous stop bit ends so frames can run back to back.
module uart_tx_byte
    import result_tx_seq_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       ending,
    output logic       TxD
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BIW = $clog2(UART_FRAME_BITS);

    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_PRE   = CW'(CLKS_PER_BIT - 2);
    localparam logic [BIW-1:0] BIT_STOP  = BIW'(UART_FRAME_BITS - 1);
    localparam logic [BIW-1:0] BIT_DLAST = BIW'(UART_DATA_BITS);

    logic           busy_q;
    logic [CW-1:0]  cnt_q;
    logic [BIW-1:0] bit_q;
    logic [7:0]     shift_q;
    logic           txd_q;
    logic           bit_end;

    assign bit_end = busy_q && (cnt_q == CNT_LAST);
    assign ready   = !busy_q || (bit_end && (bit_q == BIT_STOP));
    // one cycle of warning before the stop bit finishes
    assign ending  = busy_q && (bit_q == BIT_STOP) && (cnt_q == CNT_PRE);
    assign TxD     = txd_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= UART_STOP_BIT;
        end else if (start && ready) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= data;
            txd_q   <= UART_START_BIT;
        end else if (busy_q) begin
            if (bit_end) begin
                cnt_q <= '0;
                if (bit_q == BIT_STOP) begin
                    busy_q <= 1'b0;
                    bit_q  <= '0;
                    txd_q  <= UART_STOP_BIT;
                end else begin
                    bit_q   <= bit_q + BIW'(1);
                    txd_q   <= (bit_q == BIT_DLAST) ? UART_STOP_BIT
                                                    : shift_q[0];
                    shift_q <= {1'b0, shift_q[7:1]};
                end
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/result_tx_seq.sv
// Result buffer plus word/byte sequencer feeding a UART serializer.
// Define RESULT_TX_CHECKSUM_EN to append an XOR checksum byte.
module result_tx_seq
    import result_tx_seq_pkg::*;
#(
    parameter int UNITS_Y      = 2,
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              data_valid_in,
    input  logic [7:0]        address_write_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              TxD,
    output logic              tx_busy,
    output logic              done,
    output logic              overrun
);

    localparam int NB = DATA_W / 8;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int NB_LAST = NB + 1;
`else
    localparam int NB_LAST = NB;
`endif
    localparam int AW = (UNITS_Y > 1) ? $clog2(UNITS_Y) : 1;
    localparam int BW = $clog2(NB_LAST + 1);

    localparam logic [AW-1:0] WORD_LAST = AW'(UNITS_Y - 1);
    localparam logic [7:0]    ADDR_LAST = 8'(UNITS_Y - 1);
    localparam logic [7:0]    ADDR_LIM  = 8'(UNITS_Y);

    logic [DATA_W-1:0] buf_q [UNITS_Y];
    logic [1:0]        state_q;
    logic [AW-1:0]     word_idx_q;
    logic [BW-1:0]     byte_q;
    logic [DATA_W-1:0] shift_q;
    logic              sent_q;
    logic              overrun_q;

    logic          wr_en;
    logic          trigger;
    logic          last_word;
    logic [BW-1:0] byte_cnt;
    logic          start;
    logic          ready;
    logic          ending;
    logic [7:0]    tx_byte;

    assign tx_busy   = (state_q == ST_LOAD) || (state_q == ST_SEND);
    assign done      = (state_q == ST_DONE);
    assign overrun   = overrun_q;
    assign wr_en     = data_valid_in && !tx_busy
                       && (address_write_in < ADDR_LIM);
    assign trigger   = wr_en && (state_q == ST_IDLE)
                       && (address_write_in == ADDR_LAST);
    assign last_word = (word_idx_q == WORD_LAST);
    assign byte_cnt  = last_word ? BW'(NB_LAST) : BW'(NB);
    assign start     = (state_q == ST_SEND) && !sent_q && ready;

`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0] csum_q;

    // checksum byte rides as an extra byte slot of the last word
    assign tx_byte = (byte_q == BW'(NB)) ? csum_q
                                         : shift_q[DATA_W-1 -: 8];

    always_ff @(posedge CLK) begin
        if (RST || state_q == ST_IDLE) begin
            csum_q <= '0;
        end else if (start) begin
            csum_q <= csum_q ^ tx_byte;
        end
    end
`else
    assign tx_byte = shift_q[DATA_W-1 -: 8];
`endif

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            buf_q[address_write_in[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            sent_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (data_valid_in && tx_busy) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        word_idx_q <= '0;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_q <= buf_q[word_idx_q];
                    byte_q  <= '0;
                    sent_q  <= 1'b0;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (start) begin
                        shift_q <= shift_q << 8;
                        byte_q  <= byte_q + BW'(1);
                        if (byte_q == byte_cnt - BW'(1)) begin
                            sent_q <= 1'b1;
                        end
                    end else if (sent_q && last_word && ready) begin
                        state_q <= ST_DONE;
                    end else if (sent_q && !last_word && ending) begin
                        // leave one idle-high cycle between words
                        word_idx_q <= word_idx_q + AW'(1);
                        state_q    <= ST_LOAD;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .data  (tx_byte),
        .ready (ready),
        .ending(ending),
        .TxD   (TxD)
    );

endmodule

// File: tb/tb_result_tx_seq.sv
// Directed bench for result_tx_seq: framing, latency, overrun,
// out-of-range writes, mid-frame reset and optional checksum byte.
module tb_result_tx_seq;

    localparam int UNITS_Y = 2;
    localparam int DATA_W  = 16;
    localparam int CPB     = 4;
    localparam int FRAME   = 10 * CPB;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int NBY = 5;
`else
    localparam int NBY = 4;
`endif
    localparam int LOGN = 8192;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              data_valid_in = 1'b0;
    logic [7:0]        address_write_in = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              TxD;
    logic              tx_busy;
    logic              done;
    logic              overrun;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;

    logic txd_log  [LOGN];
    logic busy_log [LOGN];
    logic done_log [LOGN];

    result_tx_seq #(
        .UNITS_Y     (UNITS_Y),
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .data_valid_in   (data_valid_in),
        .address_write_in(address_write_in),
        .data_in         (data_in),
        .TxD             (TxD),
        .tx_busy         (tx_busy),
        .done            (done),
        .overrun         (overrun)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // log[n] holds outputs as they stand after rising edge n
    always @(negedge CLK) begin
        if (cyc < LOGN) begin
            txd_log[cyc]  <= TxD;
            busy_log[cyc] <= tx_busy;
            done_log[cyc] <= done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d,
                      output int t);
        data_valid_in    = 1'b1;
        address_write_in = a;
        data_in          = d;
        tick();
        data_valid_in    = 1'b0;
        t                = cyc;
    endtask

    // mode 0 plain, 1 strobes while busy, 2 out-of-range writes,
    // 3 store to the last address during the done cycle
    task automatic run(input string tag, input logic [15:0] w0,
                       input logic [15:0] w1, input logic [39:0] exp,
                       input int mode, input logic exp_ovr);
        int t;
        int e;
        int s;
        int errs;
        int ndone;
        logic [7:0] b;
        logic [7:0] eb;
        logic bit_e;
        wr(8'd0, w0, t);
        if (mode == 2) begin
            wr(8'd5, 16'hDEAD, t);
            wr(8'd4, 16'hDEAD, t);
        end
        wr(8'd1, w1, t);
        e = t + 2 + NBY * FRAME + 1;
        while (cyc < e + 5) begin
            data_valid_in = 1'b0;
            if (mode == 1 && (cyc == t + 52 || cyc == t + 53)) begin
                data_valid_in    = 1'b1;
                address_write_in = (cyc == t + 52) ? 8'd0 : 8'd1;
                data_in          = 16'hFFFF;
            end
            if (mode == 3 && cyc == e) begin
                data_valid_in    = 1'b1;
                address_write_in = 8'd1;
                data_in          = w1;
            end
            tick();
        end
        data_valid_in = 1'b0;

        chk({tag, ".busy_pre"},   32'(busy_log[t-1]), 32'd0);
        chk({tag, ".busy_rise"},  32'(busy_log[t]),   32'd1);
        chk({tag, ".txd_pre"},    32'(txd_log[t+1]),  32'd1);
        chk({tag, ".start_fall"}, 32'(txd_log[t+2]),  32'd0);
        for (int k = 0; k < NBY; k++) begin
            s    = t + 2 + k * FRAME + ((k >= 2) ? 1 : 0);
            eb   = exp[39 - 8*k -: 8];
            b    = '0;
            errs = 0;
            for (int bi = 0; bi < 10; bi++) begin
                bit_e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : eb[bi-1];
                for (int c = 0; c < CPB; c++) begin
                    if (txd_log[s + bi*CPB + c] !== bit_e) errs++;
                end
                if (bi >= 1 && bi <= 8) begin
                    b[bi-1] = txd_log[s + bi*CPB + CPB/2];
                end
            end
            chk($sformatf("%s.byte%0d", tag, k), 32'(b), 32'(eb));
            chk($sformatf("%s.wave%0d", tag, k), 32'(errs), 32'd0);
        end
        ndone = 0;
        for (int i = t; i <= e + 4; i++) begin
            if (done_log[i] === 1'b1) ndone++;
        end
        chk({tag, ".done_at"},   32'(done_log[e]),  32'd1);
        chk({tag, ".done_cnt"},  32'(ndone),        32'd1);
        chk({tag, ".busy_last"}, 32'(busy_log[e-1]), 32'd1);
        chk({tag, ".busy_fall"}, 32'(busy_log[e]),  32'd0);
        chk({tag, ".txd_idle"},  32'(txd_log[e+3]), 32'd1);
        if (mode == 3) begin
            chk({tag, ".no_retrig1"}, 32'(busy_log[e+1]), 32'd0);
            chk({tag, ".no_retrig2"}, 32'(busy_log[e+2]), 32'd0);
        end
        chk({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        int t;
        RST = 1'b1;
        repeat (3) tick();
        chk("rst.txd",     32'(TxD),     32'd1);
        chk("rst.busy",    32'(tx_busy), 32'd0);
        chk("rst.done",    32'(done),    32'd0);
        chk("rst.overrun", 32'(overrun), 32'd0);
        RST = 1'b0;
        repeat (2) tick();

        run("A", 16'h1234, 16'hABCD, 40'h1234ABCD40, 3, 1'b0);
        run("B", 16'h1234, 16'hABCD, 40'h1234ABCD40, 1, 1'b1);
        run("C", 16'h1234, 16'hABCD, 40'h1234ABCD40, 2, 1'b1);

        wr(8'd0, 16'h1234, t);
        wr(8'd1, 16'hABCD, t);
        while (cyc < t + 99) tick();
        chk("D.busy_pre", 32'(tx_busy), 32'd1);
        RST = 1'b1;
        tick();
        chk("D.txd",     32'(TxD),     32'd1);
        chk("D.busy",    32'(tx_busy), 32'd0);
        chk("D.done",    32'(done),    32'd0);
        chk("D.overrun", 32'(overrun), 32'd0);
        RST = 1'b0;
        repeat (5) tick();
        chk("D.stay_busy", 32'(tx_busy), 32'd0);
        chk("D.stay_txd",  32'(TxD),     32'd1);

        run("E", 16'h1234, 16'hABCD, 40'h1234ABCD40, 0, 1'b0);
        run("F", 16'h1235, 16'hABCD, 40'h1235ABCD41, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

endmodule
